trng_conditioner: RTL and testbench

Conditioning stage between the free-running ring-oscillator XOR bit and the VGA pixel path. Synchronizes the asynchronous raw bit, samples it at a fixed rate, removes bias with a von Neumann extractor and packs unbiased bits into WIDTH-bit words. Words go into a small FIFO with a valid/ready output, and a repetition-count health test latches a fault. Downstream, the VGA stage pops one word per pixel and uses it as a 3+3+3-bit RGB value.

---
 rtl/trng_conditioner.sv | 192 +++++++++++++++++++
 tb/tb_trng_conditioner.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_conditioner.sv
// Raw ring-oscillator bit conditioner: two-flop synchronizer, fixed-rate sampler,
// von Neumann debiaser, word packer, show-ahead output FIFO and repetition-count health test.
module trng_conditioner #(
    parameter int WIDTH      = 9,
    parameter int SAMPLE_DIV = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 64
) (
    input  logic                              clk_100mhz,
    input  logic                              rst_n,
    input  logic                              raw_bit,
    input  logic                              enable,
    input  logic                              rnd_ready,
    output logic [WIDTH-1:0]                  rnd_data,
    output logic                              rnd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [7:0]                        drop_cnt,
    output logic                              health_fail
);

    localparam int DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BCNT_W = $clog2(WIDTH);
    localparam int RUN_W  = $clog2(REP_LIMIT + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } pair_state_e;

    pair_state_e         state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                b0_q, b0_d;
    logic [RUN_W-1:0]    run_len_q, run_len_d;
    logic                prev_q, prev_d;
    logic                seen_q, seen_d;
    logic                health_q, health_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [7:0]          drop_q, drop_d;
    logic [WIDTH-1:0]    mem_q [FIFO_DEPTH];

    logic                sync_bit;
    logic                tick;
    logic                load_b0;
    logic                emit_vld;
    logic                emit_bit;
    logic                fail_now;
    logic                block;
    logic                push_req;
    logic                push_ok;
    logic                pop;
    logic [WIDTH-1:0]    push_word;

    assign sync_bit = sync_q[1];
    assign tick     = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));

    // Pair FSM: state register
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Pair FSM: next state; dropping enable abandons any half-collected pair
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_FIRST;
        end else if (tick) begin
            state_d = (state_q == ST_FIRST) ? ST_SECOND : ST_FIRST;
        end
    end

    // Pair FSM: outputs
    always_comb begin
        load_b0  = 1'b0;
        emit_vld = 1'b0;
        emit_bit = b0_q;
        if (tick) begin
            if (state_q == ST_FIRST) begin
                load_b0 = 1'b1;
            end else begin
                emit_vld = (b0_q != sync_bit);
            end
        end
    end

    always_comb begin
        sync_d    = {sync_q[0], raw_bit};
        div_d     = (!enable || tick) ? '0 : div_q + DIV_W'(1);
        b0_d      = load_b0 ? sync_bit : b0_q;

        run_len_d = run_len_q;
        prev_d    = prev_q;
        seen_d    = seen_q;
        if (tick) begin
            seen_d = 1'b1;
            prev_d = sync_bit;
            if (!seen_q || (sync_bit != prev_q)) begin
                run_len_d = RUN_W'(1);
            end else if (run_len_q != RUN_W'(REP_LIMIT)) begin
                run_len_d = run_len_q + RUN_W'(1);
            end
        end
        // The tick that trips the test must already suppress its own push
        fail_now = tick && (run_len_d == RUN_W'(REP_LIMIT));
        health_d = health_q || fail_now;
        block    = health_q || fail_now;

        shreg_d   = shreg_q;
        bcnt_d    = bcnt_q;
        push_req  = 1'b0;
        push_word = {shreg_q[WIDTH-2:0], emit_bit};
        if (emit_vld && !block) begin
            shreg_d = push_word;
            if (bcnt_q == BCNT_W'(WIDTH - 1)) begin
                push_req = 1'b1;
                bcnt_d   = '0;
            end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
            end
        end

        // Space is judged on the registered level only; a same-cycle pop does not help
        push_ok  = push_req && (level_q < LVL_W'(FIFO_DEPTH));
        pop      = (level_q != '0) && rnd_ready;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        drop_d   = drop_q;
        if (push_req && !push_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            sync_q    <= '0;
            div_q     <= '0;
            b0_q      <= 1'b0;
            run_len_q <= '0;
            prev_q    <= 1'b0;
            seen_q    <= 1'b0;
            health_q  <= 1'b0;
            shreg_q   <= '0;
            bcnt_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            drop_q    <= '0;
        end else begin
            sync_q    <= sync_d;
            div_q     <= div_d;
            b0_q      <= b0_d;
            run_len_q <= run_len_d;
            prev_q    <= prev_d;
            seen_q    <= seen_d;
            health_q  <= health_d;
            shreg_q   <= shreg_d;
            bcnt_q    <= bcnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign rnd_data    = mem_q[rd_ptr_q];
    assign rnd_valid   = (level_q != '0);
    assign fifo_level  = level_q;
    assign drop_cnt    = drop_q;
    assign health_fail = health_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Scenario bench for trng_conditioner: a sample-level debiaser/packer model feeds an
// expected-word queue, and a monitor pops and compares every word the DUT hands out.
module tb_trng_conditioner;

    localparam int WIDTH      = 9;
    localparam int SAMPLE_DIV = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int REP_LIMIT  = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             raw_bit = 1'b0;
    logic             enable = 1'b0;
    logic             rnd_ready = 1'b1;
    logic [WIDTH-1:0] rnd_data;
    logic             rnd_valid;
    logic [2:0]       fifo_level;
    logic [7:0]       drop_cnt;
    logic             health_fail;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             m_have_b0;
    logic             m_b0;
    logic [WIDTH-1:0] m_word;
    int               m_cnt;
    int               m_drops;
    int               valid_cycles = 0;
    int               max_level = 0;

    trng_conditioner #(
        .WIDTH(WIDTH), .SAMPLE_DIV(SAMPLE_DIV), .FIFO_DEPTH(FIFO_DEPTH), .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .raw_bit    (raw_bit),
        .enable     (enable),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor samples mid-low-phase, after the bench has driven its inputs
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (rnd_valid) valid_cycles++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (rnd_valid && rnd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got word %03h, no word expected", rnd_data);
                end else begin
                    logic [WIDTH-1:0] exp_w;
                    exp_w = exp_q.pop_front();
                    if (rnd_data !== exp_w) begin
                        errors++;
                        $display("FAIL pop_word: got %03h expected %03h", rnd_data, exp_w);
                    end else begin
                        $display("pop word %03h at %0t", rnd_data, $time);
                    end
                end
            end
        end
    end

    function automatic void model_clear();
        m_have_b0 = 1'b0;
        m_b0      = 1'b0;
        m_word    = '0;
        m_cnt     = 0;
        m_drops   = 0;
        exp_q.delete();
    endfunction

    function automatic void model_sample(input logic b);
        if (!m_have_b0) begin
            m_b0      = b;
            m_have_b0 = 1'b1;
        end else begin
            m_have_b0 = 1'b0;
            if (m_b0 != b) begin
                m_word = {m_word[WIDTH-2:0], m_b0};
                m_cnt++;
                if (m_cnt == WIDTH) begin
                    m_cnt = 0;
                    if (exp_q.size() >= FIFO_DEPTH) m_drops++;
                    else exp_q.push_back(m_word);
                end
            end
        end
    endfunction

    // Called at a negedge just after a tick edge (or reset/enable release); returns likewise
    task automatic drive_sample(input logic b, input bit use_model);
        raw_bit = b;
        if (use_model) model_sample(b);
        repeat (SAMPLE_DIV) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit discards, input bit use_model);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            drive_sample(w[i], use_model);
            drive_sample(~w[i], use_model);
            if (discards && i > 0) begin
                drive_sample(i[0], use_model);
                drive_sample(i[0], use_model);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            raw_bit = ~raw_bit;
            @(negedge clk);
        end
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic settle_and_check_drained(input string name);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d expected words never appeared, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            raw_bit = ~raw_bit;
            @(negedge clk);
        end
        #1;
        checks++;
        if (rnd_data !== 9'd0) begin errors++; $display("FAIL reset_data: got %03h required 000", rnd_data); end
        checks++;
        if (rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", rnd_valid); end
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
        checks++;
        if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health: got %b required 0", health_fail); end
        @(negedge clk);
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_unbiased();
        int v0;
        do_reset();
        v0 = valid_cycles;
        send_word(9'b101010101, 1'b0, 1'b1);
        settle_and_check_drained("unbiased");
        checks++;
        if (valid_cycles - v0 != 1) begin
            errors++;
            $display("FAIL unbiased_valid_cycles: got %0d required 1", valid_cycles - v0);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL unbiased_drop: got %0d required 0", drop_cnt); end
    endtask

    task automatic test_discard();
        int v0;
        do_reset();
        v0 = valid_cycles;
        max_level = 0;
        send_word(9'b101010101, 1'b1, 1'b1);
        settle_and_check_drained("discard");
        checks++;
        if (valid_cycles - v0 != 1) begin
            errors++;
            $display("FAIL discard_valid_cycles: got %0d required 1", valid_cycles - v0);
        end
        checks++;
        if (max_level != 1) begin errors++; $display("FAIL discard_max_level: got %0d required 1", max_level); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] words [5];
        words[0] = 9'h1A5; words[1] = 9'h0F3; words[2] = 9'h12C;
        words[3] = 9'h055; words[4] = 9'h1E0;
        do_reset();
        rnd_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_word(words[k], 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d required 4", fifo_level); end
        checks++;
        if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop: got %0d required 1", drop_cnt); end
        checks++;
        if (int'(drop_cnt) != m_drops) begin
            errors++;
            $display("FAIL bp_drop_model: got %0d model %0d", drop_cnt, m_drops);
        end
        rnd_ready = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            #2;
            checks++;
            if (rnd_valid !== 1'b1 || int'(fifo_level) != FIFO_DEPTH - i) begin
                errors++;
                $display("FAIL bp_drain_step%0d: valid %b level %0d required valid 1 level %0d",
                         i, rnd_valid, fifo_level, FIFO_DEPTH - i);
            end
            @(negedge clk);
        end
        #2;
        checks++;
        if (rnd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain_empty: valid %b level %0d required 0 0", rnd_valid, fifo_level);
        end
        settle_and_check_drained("bp");
    endtask

    task automatic test_health();
        int v0;
        do_reset();
        for (int i = 0; i < REP_LIMIT - 1; i++) drive_sample(1'b1, 1'b0);
        checks++;
        if (health_fail !== 1'b0) begin
            errors++;
            $display("FAIL health_early: got %b required 0 after %0d ticks", health_fail, REP_LIMIT - 1);
        end
        drive_sample(1'b1, 1'b0);
        checks++;
        if (health_fail !== 1'b1) begin
            errors++;
            $display("FAIL health_trip: got %b required 1 after %0d ticks", health_fail, REP_LIMIT);
        end
        v0 = valid_cycles;
        send_word(9'h155, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (valid_cycles != v0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL health_no_push: valid cycles %0d level %0d required 0 0", valid_cycles - v0, fifo_level);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL health_drop: got %0d required 0", drop_cnt); end
        checks++;
        if (health_fail !== 1'b1) begin errors++; $display("FAIL health_sticky: got %b required 1", health_fail); end
        do_reset();
        #1;
        checks++;
        if (health_fail !== 1'b0) begin errors++; $display("FAIL health_clear: got %b required 0", health_fail); end
    endtask

    task automatic test_midop();
        logic [WIDTH-1:0] w;
        w = 9'b110011011;
        do_reset();
        for (int i = WIDTH - 1; i >= WIDTH - 5; i--) begin
            drive_sample(w[i], 1'b1);
            drive_sample(~w[i], 1'b1);
        end
        drive_sample(1'b0, 1'b1);
        enable    = 1'b0;
        m_have_b0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            raw_bit = ~raw_bit;
            @(negedge clk);
        end
        enable = 1'b1;
        for (int i = WIDTH - 6; i >= 0; i--) begin
            drive_sample(w[i], 1'b1);
            drive_sample(~w[i], 1'b1);
        end
        settle_and_check_drained("midop_enable");

        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_sample(1'b1, 1'b1);
            drive_sample(1'b0, 1'b1);
        end
        do_reset();
        send_word(9'h0B6, 1'b0, 1'b1);
        settle_and_check_drained("midop_reset");
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL midop_drop: got %0d required 0", drop_cnt); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_unbiased();
        test_discard();
        test_backpressure();
        test_health();
        test_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
